neuron_array_lif: RTL and testbench

Time-multiplexed array of NUM_NEURONS leaky integrate-and-fire neurons with registered membrane potentials and parametrised data width. Input spike events are integrated one per cycle through a valid/ready port. A tick pulse starts a sequential leak/threshold sweep over all neurons. Fired neuron indices stream out through a valid/ready spike port. It succeeds the single combinational neuron in the neuron core and sits between the axon event router and the spike output FIFO.

---
 rtl/neuron_array_lif.sv | 146 ++++++++++++++
 tb/tb_neuron_array_lif.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_array_lif.sv
// Time-multiplexed leaky integrate-and-fire neuron array.
// Events integrate in IDLE; a tick sweeps leak/threshold over every neuron.
module neuron_array_lif #(
    parameter int DATA_W           = 8,
    parameter int NUM_NEURONS      = 16,
    parameter int NUM_WEIGHT_TYPES = 4,
    parameter int NIDX_W           = $clog2(NUM_NEURONS),
    parameter int WSEL_W           = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               enable_i,
    input  logic [NUM_WEIGHT_TYPES*DATA_W-1:0] weights_i,
    input  logic [DATA_W-1:0]                  leak_value_i,
    input  logic [DATA_W-1:0]                  pos_threshold_i,
    input  logic [DATA_W-1:0]                  neg_threshold_i,
    input  logic [DATA_W-1:0]                  pos_reset_i,
    input  logic [DATA_W-1:0]                  neg_reset_i,
    input  logic                               evt_valid_i,
    output logic                               evt_ready_o,
    input  logic [NIDX_W-1:0]                  evt_neuron_i,
    input  logic [WSEL_W-1:0]                  evt_wsel_i,
    input  logic                               tick_i,
    output logic                               spike_valid_o,
    input  logic                               spike_ready_i,
    output logic [NIDX_W-1:0]                  spike_neuron_o,
    output logic                               busy_o,
    output logic                               sweep_done_o,
    output logic                               tick_drop_o
);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        WAIT_OUT
    } state_t;

    localparam logic [NIDX_W-1:0] LAST_IDX = NIDX_W'(NUM_NEURONS - 1);
    localparam logic [NIDX_W:0]   NUM_N    = (NIDX_W + 1)'(NUM_NEURONS);

    state_t              state_q;
    logic [NIDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]   pot_q [NUM_NEURONS];
    logic                spike_valid_q;
    logic [NIDX_W-1:0]   spike_neuron_q;
    logic                sweep_done_q;
    logic                tick_drop_q;

    logic [DATA_W-1:0]   w_d;
    logic [DATA_W:0]     sum_d;
    logic [DATA_W-1:0]   acc_d;
    logic [DATA_W-1:0]   cur_d;
    logic [DATA_W-1:0]   leak_d;
    logic                fire_d;
    logic                neg_d;
    logic                last_d;
    logic                accept_d;

    assign evt_ready_o    = (state_q == IDLE) && !tick_i;
    assign busy_o         = (state_q != IDLE);
    assign spike_valid_o  = spike_valid_q;
    assign spike_neuron_o = spike_neuron_q;
    assign sweep_done_o   = sweep_done_q;
    assign tick_drop_o    = tick_drop_q;

    // Disabled arrays still handshake events, they just drop them.
    assign accept_d = evt_valid_i && evt_ready_o && enable_i
                      && ({1'b0, evt_neuron_i} < NUM_N);

    always_comb begin
        w_d = '0;
        for (int k = 0; k < NUM_WEIGHT_TYPES; k++) begin
            if (evt_wsel_i == WSEL_W'(k)) begin
                w_d = weights_i[k*DATA_W +: DATA_W];
            end
        end
        sum_d  = {1'b0, pot_q[evt_neuron_i]} + {1'b0, w_d};
        acc_d  = sum_d[DATA_W] ? '1 : sum_d[DATA_W-1:0];
        cur_d  = pot_q[idx_q];
        leak_d = (cur_d > leak_value_i) ? (cur_d - leak_value_i) : '0;
        fire_d = (leak_d >= pos_threshold_i);
        neg_d  = (leak_d <= neg_threshold_i);
        last_d = (idx_q == LAST_IDX);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            spike_valid_q  <= 1'b0;
            spike_neuron_q <= '0;
            sweep_done_q   <= 1'b0;
            tick_drop_q    <= 1'b0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                pot_q[n] <= '0;
            end
        end else begin
            sweep_done_q <= 1'b0;
            tick_drop_q  <= 1'b0;
            if (tick_i && (state_q != IDLE)) begin
                tick_drop_q <= 1'b1;
            end
            if (accept_d) begin
                pot_q[evt_neuron_i] <= acc_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (tick_i && enable_i) begin
                        state_q <= SWEEP;
                        idx_q   <= '0;
                    end
                end
                SWEEP: begin
                    if (fire_d) begin
                        pot_q[idx_q]   <= pos_reset_i;
                        spike_valid_q  <= 1'b1;
                        spike_neuron_q <= idx_q;
                        state_q        <= WAIT_OUT;
                    end else begin
                        pot_q[idx_q] <= neg_d ? neg_reset_i : leak_d;
                        if (last_d) begin
                            state_q      <= IDLE;
                            sweep_done_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                WAIT_OUT: begin
                    if (spike_ready_i) begin
                        spike_valid_q <= 1'b0;
                        if (last_d) begin
                            state_q      <= IDLE;
                            sweep_done_q <= 1'b1;
                        end else begin
                            state_q <= SWEEP;
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_array_lif.sv
// Bench for neuron_array_lif: vector table, directed corner sequences,
// and randomized events/sweeps against an array-based reference model.
module tb_neuron_array_lif;

    localparam int N    = 4;
    localparam int LEAK = 5;
    localparam int PTHR = 100;
    localparam int NTHR = 2;
    localparam int PRST = 0;
    localparam int NRST = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [7:0]  wt [4];
    logic [31:0] weights;
    logic        evt_valid = 1'b0;
    logic        evt_ready;
    logic [1:0]  evt_neuron = '0;
    logic [7:0]  evt_wsel = '0;
    logic        tick = 1'b0;
    logic        spike_valid;
    logic        spike_ready = 1'b0;
    logic [1:0]  spike_neuron;
    logic        busy;
    logic        sweep_done;
    logic        tick_drop;

    int vecs = 0;
    int errs = 0;
    int mpot [N];

    assign weights = {wt[3], wt[2], wt[1], wt[0]};

    always #5 clk = ~clk;

    neuron_array_lif #(
        .DATA_W(8), .NUM_NEURONS(N), .NUM_WEIGHT_TYPES(4),
        .NIDX_W(2), .WSEL_W(8)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .weights_i(weights),
        .leak_value_i(8'(LEAK)),
        .pos_threshold_i(8'(PTHR)),
        .neg_threshold_i(8'(NTHR)),
        .pos_reset_i(8'(PRST)),
        .neg_reset_i(8'(NRST)),
        .evt_valid_i(evt_valid), .evt_ready_o(evt_ready),
        .evt_neuron_i(evt_neuron), .evt_wsel_i(evt_wsel),
        .tick_i(tick),
        .spike_valid_o(spike_valid), .spike_ready_i(spike_ready),
        .spike_neuron_o(spike_neuron),
        .busy_o(busy), .sweep_done_o(sweep_done), .tick_drop_o(tick_drop)
    );

    typedef struct {
        int n;
        int w;
        int exp;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_int(input int n, input int w);
        int wv;
        wv = (w < 4) ? int'(wt[w]) : 0;
        if (enable) mpot[n] = (mpot[n] + wv > 255) ? 255 : mpot[n] + wv;
    endfunction

    task automatic check_pots(input string name);
        for (int k = 0; k < N; k++) check(name, int'(dut.pot_q[k]), mpot[k]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick = 1'b0;
        evt_valid = 1'b0;
        spike_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) mpot[k] = 0;
    endtask

    task automatic send_evt(input int n, input int w);
        evt_valid = 1'b1;
        evt_neuron = 2'(n);
        evt_wsel = 8'(w);
        #1;
        check("evt_ready", int'(evt_ready), 1);
        @(negedge clk);
        evt_valid = 1'b0;
        model_int(n, w);
        check("evt_pot", int'(dut.pot_q[n]), mpot[n]);
    endtask

    // mode 0: random ready, 1: always ready, 2: ready after 5 stalled cycles
    task automatic do_sweep(input int mode, input bit inject, input bit chk_lat);
        int  expq [$];
        int  q;
        int  cyc = 0;
        int  stall = 0;
        bit  done = 0;
        bit  hs = 0;
        for (int k = 0; k < N; k++) begin
            q = (mpot[k] > LEAK) ? mpot[k] - LEAK : 0;
            if (q >= PTHR) begin
                mpot[k] = PRST;
                expq.push_back(k);
            end else if (q <= NTHR) begin
                mpot[k] = NRST;
            end else begin
                mpot[k] = q;
            end
        end
        tick = 1'b1;
        #1;
        check("ready_tick", int'(evt_ready), 0);
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            tick = 1'b0;
            if (inject && cyc == 3) tick = 1'b1;
            if (inject && cyc == 4) check("tick_drop", int'(tick_drop), 1);
            if (hs) begin
                void'(expq.pop_front());
                check("spike_drop", int'(spike_valid), 0);
                hs = 0;
            end
            if (sweep_done) begin
                done = 1;
            end else begin
                check("busy", int'(busy), 1);
                check("ready_busy", int'(evt_ready), 0);
            end
            spike_ready = 1'b0;
            if (spike_valid) begin
                check("spike_pending", int'(expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    check("spike_idx", int'(spike_neuron), expq[0]);
                end
                if (mode == 1 || (mode == 0 && $urandom_range(0, 1) == 1)
                    || (mode == 2 && stall >= 5)) begin
                    spike_ready = 1'b1;
                    hs = 1;
                    stall = 0;
                end else begin
                    stall++;
                end
            end
        end
        tick = 1'b0;
        spike_ready = 1'b0;
        check("sweep_timeout", int'(done), 1);
        check("spike_left", expq.size(), 0);
        if (chk_lat) check("latency", cyc - 1, N);
        check_pots("sweep_pot");
    endtask

    task automatic post_sweep();
        @(negedge clk);
        check("idle_after", int'(busy), 0);
        check("single_done", int'(sweep_done), 0);
    endtask

    initial begin
        wt[0] = 8'd10; wt[1] = 8'd20; wt[2] = 8'd30; wt[3] = 8'd40;
        for (int i = 0; i < 7; i++) tbl[i] = '{1, 3, (i + 1) * 40 > 255 ? 255 : (i + 1) * 40};
        tbl[7] = '{1, 7, 255};

        do_reset();
        check("rst_spike_valid", int'(spike_valid), 0);
        check("rst_spike_neuron", int'(spike_neuron), 0);
        check("rst_done", int'(sweep_done), 0);
        check("rst_drop", int'(tick_drop), 0);
        check("rst_busy", int'(busy), 0);
        check_pots("rst_pot");

        // saturation, back-to-back
        for (int i = 0; i < 8; i++) begin
            evt_valid = 1'b1;
            evt_neuron = 2'(tbl[i].n);
            evt_wsel = 8'(tbl[i].w);
            #1;
            check("sat_ready", int'(evt_ready), 1);
            @(negedge clk);
            model_int(tbl[i].n, tbl[i].w);
            check("sat_pot", int'(dut.pot_q[tbl[i].n]), tbl[i].exp);
        end
        evt_valid = 1'b0;

        // single fire
        do_reset();
        for (int i = 0; i < 3; i++) send_evt(2, 3);
        do_sweep(1, 0, 0);
        post_sweep();

        // leak without fire, neg reset, latency
        do_reset();
        send_evt(0, 3);
        send_evt(0, 0);
        wt[0] = 8'd4;
        send_evt(3, 0);
        wt[0] = 8'd10;
        do_sweep(1, 0, 1);
        post_sweep();

        // backpressure
        do_reset();
        for (int i = 0; i < 3; i++) send_evt(1, 3);
        for (int i = 0; i < 3; i++) send_evt(3, 3);
        do_sweep(2, 0, 0);
        post_sweep();

        // tick during sweep
        do_reset();
        do_sweep(1, 1, 1);
        post_sweep();

        // tick and event together: event waits for the sweep
        evt_valid = 1'b1;
        evt_neuron = 2'd0;
        evt_wsel = 8'd1;
        do_sweep(1, 0, 0);
        check("evt_after_done", int'(evt_ready), 1);
        @(negedge clk);
        evt_valid = 1'b0;
        model_int(0, 1);
        check("evt_late_pot", int'(dut.pot_q[0]), mpot[0]);

        // enable low: events dropped, ticks ignored silently
        enable = 1'b0;
        send_evt(1, 3);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("dis_busy", int'(busy), 0);
        check("dis_drop", int'(tick_drop), 0);
        enable = 1'b1;

        // reset while waiting for spike_ready
        do_reset();
        for (int i = 0; i < 3; i++) send_evt(0, 3);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int i = 0; i < 20 && !spike_valid; i++) @(negedge clk);
        check("wo_spike_seen", int'(spike_valid), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("wo_rst_valid", int'(spike_valid), 0);
        check("wo_rst_busy", int'(busy), 0);
        for (int k = 0; k < N; k++) mpot[k] = 0;
        check_pots("wo_rst_pot");
        @(negedge clk);
        rst = 1'b0;
        send_evt(2, 7);
        send_evt(2, 4);

        // randomized rounds
        for (int r = 0; r < 40; r++) begin
            int ne;
            ne = $urandom_range(0, 6);
            for (int e = 0; e < ne; e++) begin
                send_evt($urandom_range(0, N - 1), $urandom_range(0, 5));
            end
            do_sweep(0, 1'($urandom_range(0, 1)), 0);
            post_sweep();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
